// File: rtl/spi_regs_pkg.sv
// Shared constants, state encoding and address decode for the SPI register-bank controller.
package spi_regs_pkg;

  localparam int unsigned ADDR_ID   = 32'h00;
  localparam int unsigned ADDR_CTRL = 32'h01;
  localparam int unsigned CFG_BASE  = 32'h02;
  localparam int unsigned STAT_BASE = 32'h10;
  localparam int unsigned MAP_END   = 32'h20;

  localparam int CTRL_START = 0;
  localparam int CTRL_ERR   = 1;
  localparam int CTRL_DONE  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WWAIT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    REG_ID   = 3'd0,
    REG_CTRL = 3'd1,
    REG_CFG  = 3'd2,
    REG_STAT = 3'd3,
    REG_NONE = 3'd4
  } region_t;

  // Classifies a zero-extended address into its register-map region.
  function automatic region_t decode_addr(input logic [31:0] a);
    region_t r;
    if (a == ADDR_ID)                          r = REG_ID;
    else if (a == ADDR_CTRL)                   r = REG_CTRL;
    else if (a >= CFG_BASE && a < STAT_BASE)   r = REG_CFG;
    else if (a >= STAT_BASE && a < MAP_END)    r = REG_STAT;
    else                                       r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_edge_det.sv
// Single-bit rise/fall detector built on a one-clock delayed copy of the input.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_d;

  // Delayed copy starts low so a level already high out of reset reads as a rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) din_d <= 1'b0;
    else      din_d <= din;
  end

  assign rise = din & ~din_d;
  assign fall = ~din & din_d;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-bank controller sitting behind the soft SPI slave: sequences address/read/write
// phases, holds ID/CTRL/config/status registers and merges DSP-side status and events.
module spi_reg_ctrl
  import spi_regs_pkg::*;
#(
  parameter int addr_width = 7,
  parameter int data_width = 24,
  parameter int n_cfg      = 14,
  parameter int n_stat     = 16,
  parameter logic [data_width-1:0] id_value = 24'hA5_0001
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [addr_width-1:0]       addr,
  input  logic                        addr_ready,
  input  logic                        rw,
  input  logic [data_width-1:0]       data_out,
  input  logic                        data_ready,
  output logic [data_width-1:0]       data_in,
  output logic [n_cfg*data_width-1:0] cfg_regs,
  output logic                        start_pulse,
  input  logic                        hw_we,
  input  logic [3:0]                  hw_idx,
  input  logic [data_width-1:0]       hw_wdata,
  input  logic                        hw_done,
  output logic                        err
);

  state_t state_q, state_next;

  logic addr_rise, addr_fall, data_rise, data_fall;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] data_q;
  logic [data_width-1:0] cfg_q  [n_cfg];
  logic [data_width-1:0] stat_q [n_stat];
  logic err_q, done_q;

  logic [31:0] rd_addr_ext, wr_addr_ext;
  region_t rd_region, wr_region;
  logic [3:0] rd_cfg_idx, rd_stat_idx, wr_cfg_idx;
  logic [data_width-1:0] ctrl_view, rd_val;
  logic read_entry, commit;
  logic err_set, err_clr, done_clr;

  edge_det u_addr_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (addr_ready),
    .rise (addr_rise),
    .fall (addr_fall)
  );

  edge_det u_data_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (data_ready),
    .rise (data_rise),
    .fall (data_fall)
  );

  assign rd_addr_ext = 32'(addr);
  assign wr_addr_ext = 32'(addr_q);
  assign rd_region   = decode_addr(rd_addr_ext);
  assign wr_region   = decode_addr(wr_addr_ext);
  assign rd_cfg_idx  = 4'(rd_addr_ext - CFG_BASE);
  assign rd_stat_idx = 4'(rd_addr_ext - STAT_BASE);
  assign wr_cfg_idx  = 4'(wr_addr_ext - CFG_BASE);

  // CTRL read view: start always reads back as 0, only err and done are visible.
  always_comb begin
    ctrl_view            = '0;
    ctrl_view[CTRL_ERR]  = err_q;
    ctrl_view[CTRL_DONE] = done_q;
  end

  // Read mux driven by the live address so data_in can be latched on the address rise itself.
  always_comb begin
    rd_val = '0;
    unique case (rd_region)
      REG_ID:   rd_val = id_value;
      REG_CTRL: rd_val = ctrl_view;
      REG_CFG:  rd_val = cfg_q[rd_cfg_idx];
      REG_STAT: rd_val = stat_q[rd_stat_idx];
      default:  rd_val = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_next;
  end

  // Next-state logic plus the single-cycle commit and start strobes.
  always_comb begin
    state_next  = state_q;
    read_entry  = 1'b0;
    commit      = 1'b0;
    start_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (addr_rise) begin
          read_entry = rw;
          state_next = rw ? READ : WWAIT;
        end
      end
      READ: begin
        if (addr_fall) state_next = IDLE;
      end
      WWAIT: begin
        if (data_rise)                   state_next = COMMIT;
        else if (addr_fall || data_fall) state_next = IDLE;
      end
      COMMIT: begin
        commit      = 1'b1;
        start_pulse = (wr_region == REG_CTRL) && data_q[CTRL_START];
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the address at message start and the payload when it arrives, so the commit
  // cycle does not depend on the SPI slave holding its outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (state_q == IDLE && addr_rise)  addr_q <= addr;
      if (state_q == WWAIT && data_rise) data_q <= data_out;
    end
  end

  // Read data is latched once at READ entry and held for the rest of the message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            data_in <= '0;
    else if (read_entry) data_in <= rd_val;
  end

  // Config registers are written only from the commit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < n_cfg; k++) cfg_q[k] <= '0;
    end else if (commit && wr_region == REG_CFG) begin
      cfg_q[wr_cfg_idx] <= data_q;
    end
  end

  // Status registers belong to the DSP side; SPI can never write them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < n_stat; k++) stat_q[k] <= '0;
    end else if (hw_we) begin
      stat_q[hw_idx] <= hw_wdata;
    end
  end

  assign err_set  = (read_entry && rd_region == REG_NONE) ||
                    (commit && (wr_region inside {REG_ID, REG_STAT, REG_NONE}));
  assign err_clr  = commit && wr_region == REG_CTRL && data_q[CTRL_ERR];
  assign done_clr = commit && wr_region == REG_CTRL && data_q[CTRL_DONE];

  // Sticky flags: a set always wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (err_set)       err_q <= 1'b1;
      else if (err_clr)  err_q <= 1'b0;
      if (hw_done)       done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
    end
  end

  // Flatten the config array onto the DSP configuration bus.
  always_comb begin
    cfg_regs = '0;
    for (int k = 0; k < n_cfg; k++) cfg_regs[k*data_width +: data_width] = cfg_q[k];
  end

  assign err = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: the driver queues expected read data, a negedge
// monitor pops and compares once data_in becomes valid.
module tb_spi_reg_ctrl;

  localparam int DW    = 24;
  localparam int NCFG  = 14;
  localparam int CFG_W = NCFG * DW;

  typedef enum int {OP_READ, OP_WRITE, OP_ABORT, OP_HWW, OP_DONE} op_e;
  typedef struct {
    string         name;
    logic [DW-1:0] exp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [6:0]       addr = '0;
  logic             addr_ready = 1'b0;
  logic             rw = 1'b0;
  logic [DW-1:0]    data_out = '0;
  logic             data_ready = 1'b0;
  logic [DW-1:0]    data_in;
  logic [CFG_W-1:0] cfg_regs;
  logic             start_pulse;
  logic             hw_we = 1'b0;
  logic [3:0]       hw_idx = '0;
  logic [DW-1:0]    hw_wdata = '0;
  logic             hw_done = 1'b0;
  logic             err;

  int total = 0;
  int bad   = 0;

  exp_t rd_q[$];
  logic [CFG_W-1:0] exp_cfg = '0;
  int exp_pulses = 0;
  int seen_pulses = 0;
  int pulse_run = 0;
  bit pending = 0;
  bit prev_ar = 0;

  spi_reg_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .addr_ready  (addr_ready),
    .rw          (rw),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .data_in     (data_in),
    .cfg_regs    (cfg_regs),
    .start_pulse (start_pulse),
    .hw_we       (hw_we),
    .hw_idx      (hw_idx),
    .hw_wdata    (hw_wdata),
    .hw_done     (hw_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Direct comparison used for levels that are static between transactions.
  task automatic checkOutput(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a read started at one negedge has data_in valid at the following one.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      pending = 0;
      prev_ar = 0;
      pulse_run = 0;
    end else begin
      if (pending) begin
        pending = 0;
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_read", CFG_W'(data_in), '1);
        end else begin
          e = rd_q.pop_front();
          checkOutput(e.name, CFG_W'(data_in), CFG_W'(e.exp));
        end
      end
      if (addr_ready && rw && !prev_ar) pending = 1;
      prev_ar = addr_ready;
      if (start_pulse) begin
        pulse_run++;
      end else if (pulse_run > 0) begin
        checkOutput("start_width", CFG_W'(pulse_run), CFG_W'(1));
        seen_pulses++;
        pulse_run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one SPI message or DSP-side event; reads queue their expected data.
  task automatic applyStimulus(input string name, input op_e op, input logic [6:0] a,
                               input logic [DW-1:0] d, input bit side_en = 0,
                               input logic [3:0] side_idx = '0, input logic [DW-1:0] side_data = '0);
    exp_t e;
    tick(1);
    case (op)
      OP_READ: begin
        e.name = name;
        e.exp  = d;
        rd_q.push_back(e);
        addr = a; rw = 1'b1; addr_ready = 1'b1;
        if (side_en) begin hw_we = 1'b1; hw_idx = side_idx; hw_wdata = side_data; end
        tick(1);
        hw_we = 1'b0;
        tick(2);
        addr_ready = 1'b0;
        tick(2);
      end
      OP_WRITE: begin
        addr = a; rw = 1'b0; addr_ready = 1'b1;
        tick(2);
        data_out = d; data_ready = 1'b1;
        if (a == 7'h01 && d[0]) exp_pulses++;
        tick(1);
        if (side_en) hw_done = 1'b1;
        tick(1);
        hw_done = 1'b0;
        tick(1);
        data_ready = 1'b0; addr_ready = 1'b0;
        tick(2);
      end
      OP_ABORT: begin
        addr = a; rw = 1'b0; addr_ready = 1'b1; data_out = d;
        tick(2);
        addr_ready = 1'b0;
        tick(2);
      end
      OP_HWW: begin
        hw_we = 1'b1; hw_idx = a[3:0]; hw_wdata = d;
        tick(1);
        hw_we = 1'b0;
      end
      default: begin
        hw_done = 1'b1;
        tick(1);
        hw_done = 1'b0;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick(3);
    rst = 1'b1;
    tick(1);
    checkOutput("reset_err", CFG_W'(err), '0);
    checkOutput("reset_cfg", cfg_regs, '0);
    checkOutput("reset_data_in", CFG_W'(data_in), '0);
    checkOutput("reset_start", CFG_W'(start_pulse), '0);

    applyStimulus("read_id", OP_READ, 7'h00, 24'hA50001);
    checkOutput("err_after_id", CFG_W'(err), '0);

    applyStimulus("write_cfg5", OP_WRITE, 7'h05, 24'h123456);
    exp_cfg[3*DW +: DW] = 24'h123456;
    checkOutput("cfg_after_w5", cfg_regs, exp_cfg);
    applyStimulus("read_cfg5", OP_READ, 7'h05, 24'h123456);

    applyStimulus("write_start", OP_WRITE, 7'h01, 24'h000001);
    applyStimulus("read_ctrl_start", OP_READ, 7'h01, 24'h000000);

    applyStimulus("hw_stat2", OP_HWW, 7'h02, 24'hABCDEF);
    applyStimulus("write_ro", OP_WRITE, 7'h12, 24'h555555);
    checkOutput("err_after_ro", CFG_W'(err), CFG_W'(1));
    applyStimulus("read_stat2", OP_READ, 7'h12, 24'hABCDEF);
    applyStimulus("read_ctrl_err", OP_READ, 7'h01, 24'h000002);
    applyStimulus("clear_err", OP_WRITE, 7'h01, 24'h000002);
    checkOutput("err_cleared", CFG_W'(err), '0);
    applyStimulus("read_ctrl_clean", OP_READ, 7'h01, 24'h000000);

    applyStimulus("hw_done", OP_DONE, 7'h00, 24'h0);
    applyStimulus("read_done_set", OP_READ, 7'h01, 24'h000004);
    applyStimulus("clr_done_race", OP_WRITE, 7'h01, 24'h000004, 1'b1);
    applyStimulus("read_done_kept", OP_READ, 7'h01, 24'h000004);
    applyStimulus("clr_done", OP_WRITE, 7'h01, 24'h000004);
    applyStimulus("read_done_clr", OP_READ, 7'h01, 24'h000000);

    applyStimulus("hw_stat3", OP_HWW, 7'h03, 24'h111111);
    applyStimulus("read_stat3_old", OP_READ, 7'h13, 24'h111111, 1'b1, 4'd3, 24'h222222);
    applyStimulus("read_stat3_new", OP_READ, 7'h13, 24'h222222);

    applyStimulus("abort_cfg6", OP_ABORT, 7'h06, 24'h777777);
    checkOutput("cfg_after_abort", cfg_regs, exp_cfg);
    checkOutput("err_after_abort", CFG_W'(err), '0);
    applyStimulus("read_cfg6", OP_READ, 7'h06, 24'h000000);

    applyStimulus("read_unmapped", OP_READ, 7'h25, 24'h000000);
    checkOutput("err_unmapped", CFG_W'(err), CFG_W'(1));
    applyStimulus("read_cfg5_again", OP_READ, 7'h05, 24'h123456);

    tick(1);
    addr = 7'h07; rw = 1'b0; addr_ready = 1'b1; data_out = 24'h999999;
    tick(2);
    #2;
    rst = 1'b0;
    addr_ready = 1'b0;
    #1;
    checkOutput("rst_err", CFG_W'(err), '0);
    checkOutput("rst_cfg", cfg_regs, '0);
    checkOutput("rst_data_in", CFG_W'(data_in), '0);
    checkOutput("rst_start", CFG_W'(start_pulse), '0);
    tick(2);
    rst = 1'b1;
    exp_cfg = '0;

    applyStimulus("read_cfg5_lost", OP_READ, 7'h05, 24'h000000);
    applyStimulus("read_stat2_lost", OP_READ, 7'h12, 24'h000000);
    applyStimulus("read_id_after", OP_READ, 7'h00, 24'hA50001);
    checkOutput("err_final", CFG_W'(err), '0);

    tick(3);
    checkOutput("reads_pending", CFG_W'(rd_q.size()), '0);
    checkOutput("start_pulses", CFG_W'(seen_pulses), CFG_W'(exp_pulses));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
